// File: rtl/ad7946_ctrl.sv
// AD7946 serial-interface controller.
// Sequences cs_n/sclk for one 16-clock frame per start request and
// deserialises sdo into a 12-bit sample plus its channel tag. The ADC is
// pipelined, so each frame returns the conversion launched by the previous
// frame; the first frame after reset or power-down only primes the pipeline.
module ad7946_ctrl #(
    parameter int CLKDIV = 2,
    parameter int TCSH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        chan_req,
    input  logic        pd_req,
    output logic        busy,
    output logic        pden,
    output logic        chsel,
    output logic        cs_n,
    output logic        sclk,
    input  logic        sdo,
    output logic [11:0] dout,
    output logic        dout_chan,
    output logic        dout_valid
);

    // The shared counter times sclk half-periods and the cs_n high hold,
    // which needs one extra count for the closing cycle after busy drops.
    localparam int CNT_MAX = (CLKDIV > TCSH + 1) ? CLKDIV : TCSH + 1;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] CSH_BUSY  = CW'(TCSH);
    localparam logic [CW-1:0] CSH_LAST  = CW'(TCSH + 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        PD,
        START,
        SETUP,
        SHIFT,
        CSH
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [3:0]    bit_cnt, bit_cnt_d;
    logic [15:0]   shreg, shreg_d;
    logic          primed, primed_d;
    logic          busy_d, pden_d, chsel_d, cs_n_d, sclk_d;
    logic [11:0]   dout_d;
    logic          dout_chan_d, dout_valid_d;

    // State register: every output is a flop, reset drops the frame at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            primed     <= 1'b0;
            busy       <= 1'b0;
            pden       <= 1'b0;
            chsel      <= 1'b0;
            cs_n       <= 1'b1;
            sclk       <= 1'b0;
            dout       <= '0;
            dout_chan  <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            bit_cnt    <= bit_cnt_d;
            shreg      <= shreg_d;
            primed     <= primed_d;
            busy       <= busy_d;
            pden       <= pden_d;
            chsel      <= chsel_d;
            cs_n       <= cs_n_d;
            sclk       <= sclk_d;
            dout       <= dout_d;
            dout_chan  <= dout_chan_d;
            dout_valid <= dout_valid_d;
        end
    end

    // Next-state and next-output logic; everything holds unless a state acts.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        bit_cnt_d    = bit_cnt;
        shreg_d      = shreg;
        primed_d     = primed;
        busy_d       = busy;
        pden_d       = pden;
        chsel_d      = chsel;
        cs_n_d       = cs_n;
        sclk_d       = sclk;
        dout_d       = dout;
        dout_chan_d  = dout_chan;
        dout_valid_d = 1'b0;

        case (state)
            IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                if (pd_req) begin
                    pden_d  = 1'b1;
                    state_d = PD;
                end else if (start) begin
                    chsel_d = chan_req;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end

            PD: begin
                if (!pd_req) begin
                    pden_d   = 1'b0;
                    primed_d = 1'b0;
                    state_d  = IDLE;
                end
            end

            START: begin
                cs_n_d    = 1'b0;
                cnt_d     = '0;
                bit_cnt_d = '0;
                state_d   = SETUP;
            end

            SETUP: begin
                if (cnt == HALF_LAST) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end

            SHIFT: begin
                if (cnt == HALF_LAST) begin
                    cnt_d = '0;
                    if (sclk) begin
                        sclk_d = 1'b0;
                    end else begin
                        shreg_d   = {shreg[14:0], sdo};
                        bit_cnt_d = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            state_d = CSH;
                        end else begin
                            sclk_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end

            CSH: begin
                cnt_d = cnt + CNT_ONE;
                if (cnt == '0) begin
                    cs_n_d       = 1'b1;
                    dout_d       = shreg[14:3];
                    dout_chan_d  = shreg[15];
                    dout_valid_d = primed;
                    primed_d     = 1'b1;
                end
                if (cnt == CSH_BUSY) begin
                    busy_d = 1'b0;
                end
                if (cnt == CSH_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ad7946_ctrl.sv
// Testbench for ad7946_ctrl with a behavioural pipelined AD7946 model.
module tb_ad7946_ctrl;

    localparam int CLKDIV     = 2;
    localparam int TCSH       = 4;
    localparam int T_CS_RISE  = 3 + 33 * CLKDIV;
    localparam int T_BUSY_LOW = T_CS_RISE + TCSH;
    localparam int FRAME      = T_BUSY_LOW + 1;

    logic        clk;
    logic        reset;
    logic        start;
    logic        chan_req;
    logic        pd_req;
    logic        busy;
    logic        pden;
    logic        chsel;
    logic        cs_n;
    logic        sclk;
    logic        sdo = 1'b0;
    logic [11:0] dout;
    logic        dout_chan;
    logic        dout_valid;

    int          total = 0;
    int          bad   = 0;

    logic [11:0] conv_data = '0;
    logic [11:0] prev_data = '0;
    logic        prev_chan = 1'b0;

    logic [15:0] adc_frame   = '0;
    logic [12:0] adc_pending = '0;
    int          adc_idx     = 0;
    logic        adc_cs_prev = 1'b1;

    ad7946_ctrl #(
        .CLKDIV(CLKDIV),
        .TCSH  (TCSH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .chan_req  (chan_req),
        .pd_req    (pd_req),
        .busy      (busy),
        .pden      (pden),
        .chsel     (chsel),
        .cs_n      (cs_n),
        .sclk      (sclk),
        .sdo       (sdo),
        .dout      (dout),
        .dout_chan (dout_chan),
        .dout_valid(dout_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ADC model: cs_n fall launches a new conversion and starts shifting out
    // the previous one as {0, tag, data, 00}; each sclk fall advances one bit.
    always @(cs_n or negedge sclk) begin
        if (cs_n === 1'b0 && adc_cs_prev !== 1'b0) begin
            adc_frame   = {1'b0, adc_pending, 2'b00};
            adc_pending = {chsel, conv_data};
            adc_idx     = 15;
            sdo         = adc_frame[15];
        end else if (cs_n === 1'b0 && sclk === 1'b0) begin
            adc_idx = adc_idx - 1;
            sdo     = (adc_idx >= 0) ? adc_frame[adc_idx] : 1'b0;
        end
        adc_cs_prev = cs_n;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_sclk(input int e);
        logic s;
        s = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (e >= 2 + CLKDIV + (k - 1) * 2 * CLKDIV && e < 2 + CLKDIV + (k - 1) * 2 * CLKDIV + CLKDIV)
                s = 1'b1;
        end
        return s;
    endfunction

    // One complete frame from an idle DUT; edge 1 is the edge sampling start.
    // With poke set, stray start pulses land in SHIFT and in CSH.
    task automatic run_frame(input logic chan, input logic [11:0] data, input logic exp_valid,
                             input logic poke);
        logic        exp_chan;
        logic [11:0] exp_data;
        exp_chan  = prev_chan;
        exp_data  = prev_data;
        conv_data = data;
        chan_req  = chan;
        start     = 1'b1;
        tick();
        start    = 1'b0;
        chan_req = ~chan;
        check("busy@1", busy, 1);
        check("chsel@1", chsel, chan);
        check("cs_n@1", cs_n, 1);
        for (int e = 2; e <= FRAME; e++) begin
            start = poke && (e == 30 || e == 71);
            tick();
            check($sformatf("cs_n@%0d", e), cs_n, (e >= 2 && e < T_CS_RISE) ? 0 : 1);
            check($sformatf("sclk@%0d", e), sclk, exp_sclk(e));
            check($sformatf("busy@%0d", e), busy, (e < T_BUSY_LOW) ? 1 : 0);
            check($sformatf("chsel@%0d", e), chsel, chan);
            check($sformatf("dout_valid@%0d", e), dout_valid, (exp_valid && e == T_CS_RISE) ? 1 : 0);
            if (exp_valid && e == T_CS_RISE) begin
                check("dout", dout, exp_data);
                check("dout_chan", dout_chan, exp_chan);
            end
        end
        start     = 1'b0;
        prev_chan = chan;
        prev_data = data;
    endtask

    initial begin
        int          rises[$];
        logic        busy_prev;
        int          valid_cnt;
        logic [11:0] first_dout, last_dout;
        logic        first_chan, last_chan;
        logic [11:0] d;
        logic        c;

        reset    = 1'b1;
        start    = 1'b0;
        chan_req = 1'b0;
        pd_req   = 1'b0;
        #12;
        check("rst_cs_n", cs_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_chsel", chsel, 0);
        check("rst_pden", pden, 0);
        check("rst_busy", busy, 0);
        check("rst_dout", dout, 0);
        check("rst_dout_chan", dout_chan, 0);
        check("rst_dout_valid", dout_valid, 0);
        reset = 1'b0;
        tick();

        $display("[TB] frames after reset: chan 0,1,0");
        run_frame(1'b0, 12'($urandom), 1'b0, 1'b0);
        run_frame(1'b1, 12'($urandom), 1'b1, 1'b0);
        run_frame(1'b0, 12'($urandom), 1'b1, 1'b1);

        $display("[TB] directed sample values");
        run_frame(1'b1, 12'hABC, 1'b1, 1'b0);
        run_frame(1'b0, 12'h001, 1'b1, 1'b1);
        run_frame(1'b1, 12'($urandom), 1'b1, 1'b0);

        $display("[TB] reset in the middle of SHIFT");
        conv_data = 12'($urandom);
        chan_req  = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (2 + CLKDIV + 7 * 2 * CLKDIV - 1) tick();
        check("mid_sclk_before", sclk, 1);
        reset = 1'b1;
        #1;
        check("mid_cs_n", cs_n, 1);
        check("mid_sclk", sclk, 0);
        check("mid_busy", busy, 0);
        check("mid_dout", dout, 0);
        #2;
        reset     = 1'b0;
        prev_chan = 1'b1;
        prev_data = conv_data;
        tick();
        check("mid_idle_busy", busy, 0);
        run_frame(1'b0, 12'($urandom), 1'b0, 1'b0);
        run_frame(1'b1, 12'($urandom), 1'b1, 1'b0);

        $display("[TB] power-down with simultaneous start");
        pd_req = 1'b1;
        start  = 1'b1;
        tick();
        check("pd_pden", pden, 1);
        check("pd_busy", busy, 0);
        check("pd_cs_n", cs_n, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("pd_hold_cs_n", cs_n, 1);
            check("pd_hold_busy", busy, 0);
            check("pd_hold_pden", pden, 1);
        end
        pd_req = 1'b0;
        start  = 1'b0;
        tick();
        check("pd_exit_pden", pden, 0);
        check("pd_exit_busy", busy, 0);
        run_frame(1'b1, 12'($urandom), 1'b0, 1'b0);
        run_frame(1'b0, 12'($urandom), 1'b1, 1'b0);

        $display("[TB] start held high");
        d          = 12'($urandom);
        c          = 1'($urandom);
        conv_data  = d;
        chan_req   = c;
        start      = 1'b1;
        busy_prev  = 1'b0;
        valid_cnt  = 0;
        first_dout = '0;
        first_chan = 1'b0;
        last_dout  = '0;
        last_chan  = 1'b0;
        for (int i = 1; i < 3 * FRAME; i++) begin
            tick();
            if (busy && !busy_prev) rises.push_back(i);
            busy_prev = busy;
            if (dout_valid) begin
                if (valid_cnt == 0) begin
                    first_dout = dout;
                    first_chan = dout_chan;
                end
                last_dout = dout;
                last_chan = dout_chan;
                valid_cnt++;
            end
        end
        start = 1'b0;
        tick();
        tick();
        check("b2b_idle_busy", busy, 0);
        check("b2b_frames", rises.size(), 3);
        if (rises.size() == 3) begin
            check("b2b_first_rise", rises[0], 1);
            check("b2b_period1", rises[1] - rises[0], FRAME);
            check("b2b_period2", rises[2] - rises[1], FRAME);
        end
        check("b2b_valid_cnt", valid_cnt, 3);
        check("b2b_first_dout", first_dout, prev_data);
        check("b2b_first_chan", first_chan, prev_chan);
        check("b2b_last_dout", last_dout, d);
        check("b2b_last_chan", last_chan, c);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
